// File: rtl/ntt_bf_scheduler.sv
// ntt_bf_scheduler
// ----------------
// Sequences a single Kyber butterfly unit (q=3329, n=256) through the seven
// layers of a forward NTT or inverse NTT held in a dual-port coefficient RAM.
// Each issue cycle presents one butterfly: two read addresses and the twiddle
// ROM index. A PIPE_LAT-deep delay line re-times the address pair so that it
// arrives as the write-back address alongside the butterfly result. A drain of
// PIPE_LAT cycles separates layers, so every write of a layer reaches the RAM
// before the next layer reads anything.
//
// Optional feature: macro NTT_SCHED_INTT_EN. When it is defined, mode is
// latched at start and mode=1 selects inverse (GS) addressing and the
// descending zeta sequence. When it is undefined, mode is ignored, bf_mode is
// tied 0 and only forward addressing is built.
//
// Handshake: issue_valid is a pure valid (no ready); the consumer must accept
// the read addresses in any cycle issue_valid is 1. stall=1 is the only
// back-pressure and it suppresses issue in that same cycle. wr_valid likewise
// marks a write that must be performed in that cycle.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start, mode             begin a transform (IDLE only), 0=NTT 1=INTT
//   stall                   hold issue this cycle
//   busy, done              transform in progress / one-cycle completion pulse
//   issue_valid             rd_addr_a, rd_addr_b, zeta_idx are valid
//   rd_addr_a, rd_addr_b    butterfly operand indices j, j+len
//   zeta_idx                twiddle ROM index
//   bf_mode, layer          latched mode and current layer 0..6
//   wr_valid, wr_addr_a/b   write-back addresses, issue delayed by PIPE_LAT
module ntt_bf_scheduler #(
  parameter int N        = 256,
  parameter int LOGN     = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic       stall,
  output logic       busy,
  output logic       done,
  output logic       issue_valid,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] zeta_idx,
  output logic       bf_mode,
  output logic [2:0] layer,
  output logic       wr_valid,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b
);

  localparam logic [6:0] LAST_BF    = 7'(N / 2 - 1);
  localparam logic [2:0] LAST_LAYER = 3'(LOGN - 2);
  localparam logic [4:0] DRAIN_INIT = 5'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t     state_q, state_d;
  logic [6:0] b_q;
  logic [2:0] layer_q;
  logic [4:0] cnt_q;
  logic       mode_q;

  logic [3:0] s;
  logic [6:0] grp;
  logic [7:0] len;
  logic [7:0] addr_a;
  logic [7:0] addr_b;
  logic [6:0] zeta;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. The drain counter is loaded with PIPE_LAT-1 and the
  // layer advances in the cycle it reads 0, so the drain lasts PIPE_LAT cycles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: if (!stall && b_q == LAST_BF) state_d = DRAIN;
      DRAIN: if (cnt_q == 5'd0) state_d = (layer_q == LAST_LAYER) ? FIN : ISSUE;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Butterfly / layer / drain counters and latched mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q     <= '0;
      layer_q <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          layer_q <= '0;
          b_q     <= '0;
`ifdef NTT_SCHED_INTT_EN
          mode_q  <= mode;
`endif
        end
        ISSUE: if (!stall) begin
          b_q <= b_q + 7'd1;
          if (b_q == LAST_BF) cnt_q <= DRAIN_INIT;
        end
        DRAIN: begin
          if (cnt_q != 5'd0) begin
            cnt_q <= cnt_q - 5'd1;
          end else if (layer_q != LAST_LAYER) begin
            layer_q <= layer_q + 3'd1;
            b_q     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef NTT_SCHED_INTT_EN
  logic unused_mode;
  assign unused_mode = mode ^ mode_q;
`endif

  // Address generation: rd_addr_a is b with a 0 inserted at bit position s,
  // i.e. group index (b>>s) spread to stride 2*len plus the offset in group.
  always_comb begin
    s = 4'(LOGN - 1) - {1'b0, layer_q};
`ifdef NTT_SCHED_INTT_EN
    if (mode_q) s = {1'b0, layer_q} + 4'd1;
`endif
    grp    = b_q >> s;
    len    = 8'd1 << s;
    addr_a = ({1'b0, grp} << (s + 4'd1)) | ({1'b0, b_q} & (len - 8'd1));
    addr_b = addr_a + len;
    zeta   = (7'd1 << layer_q) + grp;
`ifdef NTT_SCHED_INTT_EN
    // For layer 0 the shift overflows to 0, and 0-1 wraps to 127 as intended.
    if (mode_q) zeta = (7'd1 << (3'd7 - layer_q)) - 7'd1 - grp;
`endif
  end

  // Output logic
  always_comb begin
    busy        = (state_q == ISSUE) || (state_q == DRAIN);
    done        = (state_q == FIN);
    issue_valid = (state_q == ISSUE) && !stall;
    rd_addr_a   = '0;
    rd_addr_b   = '0;
    zeta_idx    = '0;
    if (state_q == ISSUE) begin
      rd_addr_a = addr_a;
      rd_addr_b = addr_b;
      zeta_idx  = zeta;
    end
    layer = layer_q;
`ifdef NTT_SCHED_INTT_EN
    bf_mode = mode_q;
`else
    bf_mode = 1'b0;
`endif
  end

  // Write-back delay line: {valid, addr_a, addr_b}, advances every cycle so
  // the write-back timing is independent of stall.
  logic [16:0] dl_q [PIPE_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= {issue_valid, rd_addr_a, rd_addr_b};
      for (int i = 1; i < PIPE_LAT; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign wr_valid  = dl_q[PIPE_LAT-1][16];
  assign wr_addr_a = dl_q[PIPE_LAT-1][15:8];
  assign wr_addr_b = dl_q[PIPE_LAT-1][7:0];

endmodule
